lsu_arbiter: RTL
================

# lsu_arbiter

Two-port arbiter that shares the single load/store unit between the core data port (requester 0) and a secondary master such as a debug or DMA engine (requester 1). It accepts one request per grant cycle from either requester, drives the LSU address, store-data, write-enable and access-size lines, and tracks an outstanding load until its data returns. It then routes the load data back to the requester that issued it. The block sits between the requesters and the LSU; the top level wires `o_lsu_funct3` onto the LSU's `instr[14:12]`.

## Interface
- `RD_LAT`, default 1: LSU load latency in clock cycles from the grant cycle to valid `i_lsu_ld_data`; legal range 1–7.
- `i_clk` input 1: single clock; the arbiter FSM, pointer and counters are posedge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_r0_req` / `i_r1_req` input 1: request valid; held until granted.
- `i_r0_addr` / `i_r1_addr` input 32: byte address.
- `i_r0_wdata` / `i_r1_wdata` input 32: store data.
- `i_r0_wren` / `i_r1_wren` input 1: 1 = store, 0 = load.
- `i_r0_funct3` / `i_r1_funct3` input 3: access size/sign (SB/SH/SW, LB/LH/LW/LBU/LHU encoding).
- `o_r0_gnt` / `o_r1_gnt` output 1: request accepted this cycle (combinational).
- `o_r0_rvalid` / `o_r1_rvalid` output 1: load data valid, one-cycle pulse.
- `o_r0_rdata` / `o_r1_rdata` output 32: load data; 0 when the matching rvalid is low.
- `o_lsu_addr` output 32: address to the LSU.
- `o_lsu_st_data` output 32: store data to the LSU.
- `o_lsu_wren` output 1: write enable to the LSU.
- `o_lsu_funct3` output 3: size/sign to the LSU.
- `i_lsu_ld_data` input 32: load data from the LSU.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any `req` is high, grant exactly one requester by round-robin. The requester not granted last wins a tie. A lone request wins immediately.
- The granted requester's addr, wdata, wren and funct3 are muxed combinationally onto the `o_lsu_*` lines in the grant cycle.
- Granted store: completes in the grant cycle and generates no response. The FSM stays in IDLE, so back-to-back stores alternate fairly one per cycle.
- Granted load: latch the owner ID, addr and funct3; load the latency counter with `RD_LAT`; go to WAIT.
- WAIT: no grants are issued. `o_lsu_addr` and `o_lsu_funct3` hold the latched values and `o_lsu_wren` is 0. The counter decrements each cycle. When the counter reaches 1, capture `i_lsu_ld_data` into the response register and go to RESP.
- RESP: pulse the owner's `rvalid` with the captured data for one cycle, then return to IDLE. A grant can also be issued in the RESP cycle, so a load is followed by a new grant with no bubble.
- Round-robin pointer: updates on every grant to point at the other requester. It does not change in cycles with no grant.
- Idle LSU lines: when no request is granted and the FSM is not in WAIT, `o_lsu_wren` is 0 and `o_lsu_addr`, `o_lsu_st_data` and `o_lsu_funct3` are 0.
- Unknown funct3 values pass through unchanged; the LSU decides what they do.

## Timing
- Reset values:
  - All `gnt`, `rvalid`, `rdata` and `o_lsu_*` outputs are 0.
  - FSM is in IDLE and the counter is 0.
  - The pointer favours requester 0 first.
- Store latency: 0 cycles (grant in the same cycle as the request).
- Load latency: grant in cycle N, `rvalid` in cycle N+RD_LAT+1.
- Load throughput: one load per RD_LAT+1 cycles.
- Requests arriving during WAIT are stalled (`gnt` = 0) and must be held by the requester.
- Reset asserted mid-load: the FSM returns to IDLE immediately, no `rvalid` is produced, and the captured data is discarded.
- Simultaneous `rvalid` and new grant in the RESP cycle are legal. The new grant may go to the same requester that is receiving data.

## Configuration
- `LSU_ARB_FIXED_PRIO_EN` defined: round-robin is replaced by fixed priority. Requester 0 always wins a tie and the pointer logic is removed. Requester 1 is served only when `i_r0_req` is 0.
- `LSU_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described in Operation.

## Test plan
- Reset, then r0 load at addr 0x10 with funct3 = 3'b010 and LSU returning 0xDEADBEEF, RD_LAT = 1: `o_r0_gnt` in cycle 0; `o_r0_rvalid` with 0xDEADBEEF in cycle 2; `o_r1_rvalid` stays 0.
- r0 and r1 both store continuously (r0 to 0x7000, r1 to 0x7010): grants alternate r0, r1, r0, r1 starting with r0; `o_lsu_wren` = 1 every cycle. With `LSU_ARB_FIXED_PRIO_EN`, r0 is granted every cycle.
- r1 load at 0x7100 (LW) with r0 store to 0x7020 arriving during WAIT: `o_r0_gnt` stays 0 until the RESP cycle; `o_r0_gnt` = 1 in the same cycle `o_r1_rvalid` = 1.
- RD_LAT = 3, r0 load: `o_lsu_addr` is held for 3 WAIT cycles with `o_lsu_wren` = 0; `o_r0_rvalid` appears in cycle 4.
- `i_rst_n` asserted in the WAIT cycle of an r0 load: no `rvalid` for the rest of the test; after release, an r1 request is granted first if r1 requests alone; if both request, r0 is granted first.
- Idle bus with both `req` = 0 for 5 cycles: all `o_lsu_*` are 0 and the round-robin pointer is unchanged.

Source files
------------

// File: rtl/lsu_arbiter_if.sv
// lsu_arbiter_if: request/response and LSU bus signals shared by the two
// requesters, the LSU and the lsu_arbiter. The arbiter uses the slave
// modport; the requester/LSU side uses the master modport.

interface lsu_arbiter_if;
    logic        i_r0_req;
    logic [31:0] i_r0_addr;
    logic [31:0] i_r0_wdata;
    logic        i_r0_wren;
    logic [2:0]  i_r0_funct3;
    logic        o_r0_gnt;
    logic        o_r0_rvalid;
    logic [31:0] o_r0_rdata;

    logic        i_r1_req;
    logic [31:0] i_r1_addr;
    logic [31:0] i_r1_wdata;
    logic        i_r1_wren;
    logic [2:0]  i_r1_funct3;
    logic        o_r1_gnt;
    logic        o_r1_rvalid;
    logic [31:0] o_r1_rdata;

    logic [31:0] o_lsu_addr;
    logic [31:0] o_lsu_st_data;
    logic        o_lsu_wren;
    logic [2:0]  o_lsu_funct3;
    logic [31:0] i_lsu_ld_data;

    modport slave (
        input  i_r0_req, i_r0_addr, i_r0_wdata, i_r0_wren, i_r0_funct3,
        output o_r0_gnt, o_r0_rvalid, o_r0_rdata,
        input  i_r1_req, i_r1_addr, i_r1_wdata, i_r1_wren, i_r1_funct3,
        output o_r1_gnt, o_r1_rvalid, o_r1_rdata,
        output o_lsu_addr, o_lsu_st_data, o_lsu_wren, o_lsu_funct3,
        input  i_lsu_ld_data
    );

    modport master (
        output i_r0_req, i_r0_addr, i_r0_wdata, i_r0_wren, i_r0_funct3,
        input  o_r0_gnt, o_r0_rvalid, o_r0_rdata,
        output i_r1_req, i_r1_addr, i_r1_wdata, i_r1_wren, i_r1_funct3,
        input  o_r1_gnt, o_r1_rvalid, o_r1_rdata,
        input  o_lsu_addr, o_lsu_st_data, o_lsu_wren, o_lsu_funct3,
        output i_lsu_ld_data
    );
endinterface

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: shares one load/store unit between the core data port
// (requester 0) and a secondary master (requester 1). Stores complete in
// the grant cycle; a load waits RD_LAT cycles in WAIT, its data is captured
// and returned to the issuing requester in RESP, where a new grant may
// already be issued.
// Build option: define LSU_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed priority (requester 0 always wins).

module lsu_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    lsu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;
    logic        owner_q;
    logic [31:0] ld_addr_q;
    logic [2:0]  ld_funct3_q;
    logic [31:0] resp_data_q;

    logic        can_grant;
    logic        gnt0;
    logic        gnt1;
    logic        gnt_any;
    logic        gnt_wren;
    logic        load_gnt;
    logic        capture;

`ifndef LSU_ARB_FIXED_PRIO_EN
    logic        ptr_q;
`endif

    // Pick at most one requester; grants are blocked only while a load is in flight.
    always_comb begin
        can_grant = (state_q != WAIT);
`ifdef LSU_ARB_FIXED_PRIO_EN
        gnt0 = can_grant && bus.i_r0_req;
        gnt1 = can_grant && bus.i_r1_req && !bus.i_r0_req;
`else
        gnt0 = can_grant && bus.i_r0_req && (!bus.i_r1_req || !ptr_q);
        gnt1 = can_grant && bus.i_r1_req && (!bus.i_r0_req || ptr_q);
`endif
        gnt_any  = gnt0 || gnt1;
        gnt_wren = gnt0 ? bus.i_r0_wren : bus.i_r1_wren;
        load_gnt = gnt_any && !gnt_wren;
    end

`ifndef LSU_ARB_FIXED_PRIO_EN
    // Round-robin pointer flips to the other requester on every grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= 1'b0;
        end else if (gnt0) begin
            ptr_q <= 1'b1;
        end else if (gnt1) begin
            ptr_q <= 1'b0;
        end
    end
`endif

    // Next-state and latency counter; capture happens on the last WAIT cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (load_gnt) begin
                    state_d = WAIT;
                    cnt_d   = 3'(RD_LAT);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State register and counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Remember who issued the load and what it addressed, held through WAIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner_q     <= 1'b0;
            ld_addr_q   <= 32'd0;
            ld_funct3_q <= 3'd0;
        end else if (load_gnt) begin
            owner_q     <= gnt1;
            ld_addr_q   <= gnt1 ? bus.i_r1_addr : bus.i_r0_addr;
            ld_funct3_q <= gnt1 ? bus.i_r1_funct3 : bus.i_r0_funct3;
        end
    end

    // Response register takes the LSU data when the latency expires.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            resp_data_q <= 32'd0;
        end else if (capture) begin
            resp_data_q <= bus.i_lsu_ld_data;
        end
    end

    // LSU bus mux: latched load during WAIT, granted requester otherwise, else zeros.
    always_comb begin
        bus.o_lsu_addr    = 32'd0;
        bus.o_lsu_st_data = 32'd0;
        bus.o_lsu_wren    = 1'b0;
        bus.o_lsu_funct3  = 3'd0;
        if (state_q == WAIT) begin
            bus.o_lsu_addr   = ld_addr_q;
            bus.o_lsu_funct3 = ld_funct3_q;
        end else if (gnt0) begin
            bus.o_lsu_addr    = bus.i_r0_addr;
            bus.o_lsu_st_data = bus.i_r0_wdata;
            bus.o_lsu_wren    = bus.i_r0_wren;
            bus.o_lsu_funct3  = bus.i_r0_funct3;
        end else if (gnt1) begin
            bus.o_lsu_addr    = bus.i_r1_addr;
            bus.o_lsu_st_data = bus.i_r1_wdata;
            bus.o_lsu_wren    = bus.i_r1_wren;
            bus.o_lsu_funct3  = bus.i_r1_funct3;
        end
    end

    // Grants and load-data return; rdata is forced to zero outside the response pulse.
    always_comb begin
        bus.o_r0_gnt    = gnt0;
        bus.o_r1_gnt    = gnt1;
        bus.o_r0_rvalid = (state_q == RESP) && !owner_q;
        bus.o_r1_rvalid = (state_q == RESP) && owner_q;
        bus.o_r0_rdata  = bus.o_r0_rvalid ? resp_data_q : 32'd0;
        bus.o_r1_rdata  = bus.o_r1_rvalid ? resp_data_q : 32'd0;
    end

endmodule
